// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor_if
// Description : Fetch-side lookup and EX-side resolution signals of the
//               branch predictor.
//               master : the core (drives pc and the update strobe,
//                        consumes the prediction)
//               slave  : the predictor
//               pc/pred_*/next_pc   - IF-stage lookup
//               update_*            - one-cycle EX resolution strobe
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_predictor_if #(
    parameter int XLEN      = 32,
    parameter int HIST_BITS = 2
);
    // pred_hist / update_hist are at least one bit wide even in bimodal mode
    localparam int c_hw = (HIST_BITS > 0) ? HIST_BITS : 1;

    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic [XLEN-1:0] next_pc;
    logic [c_hw-1:0] pred_hist;

    logic            update_valid;
    logic [XLEN-1:0] update_pc;
    logic            update_taken;
    logic [XLEN-1:0] update_target;
    logic [c_hw-1:0] update_hist;
    logic            update_mispredict;

    modport master (
        output pc,
        input  pred_taken, pred_target, next_pc, pred_hist,
        output update_valid, update_pc, update_taken, update_target,
               update_hist, update_mispredict
    );

    modport slave (
        input  pc,
        output pred_taken, pred_target, next_pc, pred_hist,
        input  update_valid, update_pc, update_taken, update_target,
               update_hist, update_mispredict
    );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped BTB plus gshare PHT of 2-bit saturating
//               counters. Supplies the next fetch PC combinationally and
//               learns from a one-cycle EX resolution strobe.
//   clk              - rising-edge clock
//   reset            - synchronous active-high reset
//   bp               - branch_predictor_if.slave (lookup + update signals)
//   mispredict_count - wrapping count of resolved mispredictions
// Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 16,
    parameter int HIST_BITS = 2,
    parameter int CNT_W     = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    branch_predictor_if.slave     bp,
    output logic [CNT_W-1:0]      mispredict_count
);
    localparam int c_idx   = $clog2(ENTRIES);
    localparam int c_tag_w = XLEN - c_idx - 2;
    localparam int c_hw    = (HIST_BITS > 0) ? HIST_BITS : 1;

    // ---------------- state ----------------
    logic               r_valid  [ENTRIES];
    logic [c_tag_w-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]    r_target [ENTRIES];
    logic [1:0]         r_pht    [ENTRIES];
    logic [c_hw-1:0]    r_ghr;
    logic [CNT_W-1:0]   r_mis_cnt;

    // ---------------- index / tag fields ----------------
    logic [c_idx-1:0]   w_bidx, w_pidx, w_upd_bidx, w_upd_pidx;
    logic [c_idx-1:0]   w_ghr_ext, w_upd_hist_ext;
    logic [c_tag_w-1:0] w_tag, w_upd_tag;
    logic [c_hw-1:0]    w_ghr_next;
    logic [XLEN-1:0]    w_pc_plus4;
    logic               w_hit;

    generate
        if (HIST_BITS == 0) begin : g_bimodal
            assign w_ghr_ext      = '0;
            assign w_upd_hist_ext = '0;
            assign w_ghr_next     = '0;
            wire w_unused_hist = ^{r_ghr, bp.update_hist};
        end else begin : g_gshare
            assign w_ghr_ext      = c_idx'(r_ghr);
            // Update index comes from the fetch-time snapshot, not the live GHR,
            // so in-flight branches train the same counter they were predicted by.
            assign w_upd_hist_ext = c_idx'(bp.update_hist);
            if (HIST_BITS == 1) begin : g_hist1
                assign w_ghr_next = bp.update_taken;
            end else begin : g_histn
                assign w_ghr_next = {r_ghr[HIST_BITS-2:0], bp.update_taken};
            end
        end
    endgenerate

    assign w_bidx     = bp.pc[c_idx+1:2];
    assign w_tag      = bp.pc[XLEN-1:c_idx+2];
    assign w_pidx     = w_bidx ^ w_ghr_ext;
    assign w_upd_bidx = bp.update_pc[c_idx+1:2];
    assign w_upd_tag  = bp.update_pc[XLEN-1:c_idx+2];
    assign w_upd_pidx = w_upd_bidx ^ w_upd_hist_ext;

    // Word-aligned fetch: the low PC bits carry no information here
    wire w_unused_lsbs = ^{bp.pc[1:0], bp.update_pc[1:0]};

    // ---------------- lookup (reads pre-update state) ----------------
    assign w_pc_plus4     = bp.pc + XLEN'(4);
    assign w_hit          = r_valid[w_bidx] && (r_tag[w_bidx] == w_tag);
    assign bp.pred_taken  = !reset && w_hit && r_pht[w_pidx][1];
    assign bp.pred_target = bp.pred_taken ? r_target[w_bidx] : w_pc_plus4;
    assign bp.next_pc     = bp.pred_target;
    assign bp.pred_hist   = r_ghr;
    assign mispredict_count = r_mis_cnt;

    // ---------------- control state (reset) ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_pht[i]   <= 2'b01;
            end
            r_ghr     <= '0;
            r_mis_cnt <= '0;
        end else if (bp.update_valid) begin
            if (bp.update_taken) begin
                if (r_pht[w_upd_pidx] != 2'b11)
                    r_pht[w_upd_pidx] <= r_pht[w_upd_pidx] + 2'd1;
                // Taken branches always (re)allocate, evicting any alias
                r_valid[w_upd_bidx] <= 1'b1;
            end else if (r_pht[w_upd_pidx] != 2'b00) begin
                r_pht[w_upd_pidx] <= r_pht[w_upd_pidx] - 2'd1;
            end
            r_ghr <= w_ghr_next;
            if (bp.update_mispredict)
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
        end
    end

    // ---------------- BTB payload (qualified by r_valid, no reset) ----------------
    always_ff @(posedge clk) begin
        if (!reset && bp.update_valid && bp.update_taken) begin
            r_tag[w_upd_bidx]    <= w_upd_tag;
            r_target[w_upd_bidx] <= bp.update_target;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_predictor
// Description : Self-checking bench. dut0 is bimodal (HIST_BITS=0, CNT_W=4),
//               dut1 is gshare (HIST_BITS=2). Vector tables give per-cycle
//               inputs and the expected lookup result for that same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset0, reset1;
    logic [3:0]  cnt0;
    logic [31:0] cnt1;

    branch_predictor_if #(.XLEN(32), .HIST_BITS(0)) bp0 ();
    branch_predictor_if #(.XLEN(32), .HIST_BITS(2)) bp1 ();

    branch_predictor #(.XLEN(32), .ENTRIES(16), .HIST_BITS(0), .CNT_W(4)) dut0 (
        .clk(clk), .reset(reset0), .bp(bp0), .mispredict_count(cnt0));
    branch_predictor #(.XLEN(32), .ENTRIES(16), .HIST_BITS(2), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset1), .bp(bp1), .mispredict_count(cnt1));

    typedef struct {
        bit          sel;   // 0 -> dut0, 1 -> dut1
        bit          rst;
        bit          uv;
        logic [31:0] upc;
        bit          ut;
        logic [31:0] utgt;
        logic [1:0]  uh;
        bit          um;
        logic [31:0] pc;
        bit          et;
        logic [31:0] en;
        logic [1:0]  eh;
        logic [31:0] ec;
    } vec_t;

    typedef struct {
        bit          sel;
        bit          et;
        logic [31:0] en;
        logic [1:0]  eh;
        logic [31:0] ec;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(bit sel, bit rst, bit uv, logic [31:0] upc, bit ut,
                                logic [31:0] utgt, logic [1:0] uh, bit um,
                                logic [31:0] pc, bit et, logic [31:0] en,
                                logic [1:0] eh, logic [31:0] ec);
        vec_t v;
        v.sel = sel; v.rst = rst; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.uh = uh; v.um = um; v.pc = pc; v.et = et; v.en = en; v.eh = eh; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One cycle: drive after the rising edge, compare at the falling edge,
    // the update (if any) lands on the following rising edge.
    task automatic apply(input vec_t v, input string name);
        exp_t e;
        exp_t g;
        @(posedge clk);
        #1;
        if (!v.sel) begin
            reset0 = v.rst; bp0.pc = v.pc; bp0.update_valid = v.uv;
            bp0.update_pc = v.upc; bp0.update_taken = v.ut; bp0.update_target = v.utgt;
            bp0.update_hist = v.uh[0]; bp0.update_mispredict = v.um;
        end else begin
            reset1 = v.rst; bp1.pc = v.pc; bp1.update_valid = v.uv;
            bp1.update_pc = v.upc; bp1.update_taken = v.ut; bp1.update_target = v.utgt;
            bp1.update_hist = v.uh; bp1.update_mispredict = v.um;
        end
        e.sel = v.sel; e.et = v.et; e.en = v.en; e.eh = v.eh; e.ec = v.ec; e.name = name;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        if (!g.sel) begin
            chk({g.name, ".taken"},  {31'd0, bp0.pred_taken}, {31'd0, g.et});
            chk({g.name, ".next"},   bp0.next_pc, g.en);
            chk({g.name, ".target"}, bp0.pred_target, g.en);
            chk({g.name, ".hist"},   {31'd0, bp0.pred_hist}, {31'd0, g.eh[0]});
            chk({g.name, ".count"},  {28'd0, cnt0}, g.ec);
        end else begin
            chk({g.name, ".taken"},  {31'd0, bp1.pred_taken}, {31'd0, g.et});
            chk({g.name, ".next"},   bp1.next_pc, g.en);
            chk({g.name, ".target"}, bp1.pred_target, g.en);
            chk({g.name, ".hist"},   {30'd0, bp1.pred_hist}, {30'd0, g.eh});
            chk({g.name, ".count"},  cnt1, g.ec);
        end
    endtask

    initial begin
        reset0 = 1'b1; reset1 = 1'b1;
        bp0.pc = '0; bp0.update_valid = 1'b0; bp0.update_pc = '0; bp0.update_taken = 1'b0;
        bp0.update_target = '0; bp0.update_hist = '0; bp0.update_mispredict = 1'b0;
        bp1.pc = '0; bp1.update_valid = 1'b0; bp1.update_pc = '0; bp1.update_taken = 1'b0;
        bp1.update_target = '0; bp1.update_hist = '0; bp1.update_mispredict = 1'b0;

        // ---- dut0: bimodal, CNT_W=4 ----
        //            sel rst uv upc          ut utgt          uh um pc            et en            eh ec
        vecs.push_back(mk(0, 1, 1, 32'h40,  1, 32'h100, 0, 1, 32'h40,  0, 32'h44,  0, 0)); // update in reset ignored
        vecs.push_back(mk(0, 1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h40,  0, 32'h44,  0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h40,  0, 32'h44,  0, 0)); // reset defaults
        vecs.push_back(mk(0, 0, 1, 32'h40,  1, 32'h100, 0, 1, 32'h40,  0, 32'h44,  0, 0)); // 01->10
        vecs.push_back(mk(0, 0, 1, 32'h40,  1, 32'h100, 0, 0, 32'h40,  1, 32'h100, 0, 1)); // 10->11
        vecs.push_back(mk(0, 0, 1, 32'h40,  1, 32'h100, 0, 0, 32'h40,  1, 32'h100, 0, 1)); // 11 stays
        vecs.push_back(mk(0, 0, 1, 32'h40,  0, 32'h0,   0, 1, 32'h40,  1, 32'h100, 0, 1)); // 11->10
        vecs.push_back(mk(0, 0, 1, 32'h40,  0, 32'h0,   0, 0, 32'h40,  1, 32'h100, 0, 2)); // 10->01
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h40,  0, 32'h44,  0, 2));
        vecs.push_back(mk(0, 0, 1, 32'h40,  1, 32'h100, 0, 0, 32'h40,  0, 32'h44,  0, 2)); // 01->10
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h440, 0, 32'h444, 0, 2)); // tag alias miss
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h40,  1, 32'h100, 0, 2));
        vecs.push_back(mk(0, 0, 1, 32'h440, 1, 32'h200, 0, 0, 32'h440, 0, 32'h444, 0, 2)); // alias replaces
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h440, 1, 32'h200, 0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h40,  0, 32'h44,  0, 2));
        vecs.push_back(mk(0, 0, 1, 32'h80,  1, 32'h300, 0, 0, 32'h80,  0, 32'h84,  0, 2)); // same-cycle hazard
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h80,  1, 32'h300, 0, 2));
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 1, 32'hFFFFFFFC, 0, 32'h0, 0, 2)); // pc+4 wrap, unqualified mispredict
        vecs.push_back(mk(0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h40,  0, 32'h44,  0, 2));

        // ---- dut1: gshare, HIST_BITS=2 ----
        vecs.push_back(mk(1, 1, 0, 32'h0,   0, 32'h0,   0, 0, 32'h40,  0, 32'h44,  0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h40,  1, 32'h100, 0, 0, 32'h40,  0, 32'h44,  0, 0)); // PHT[0]->10, GHR=01
        vecs.push_back(mk(1, 0, 1, 32'h44,  0, 32'h0,   0, 0, 32'h40,  0, 32'h44,  1, 0)); // PHT[1]->00, GHR=10
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h40,  0, 32'h44,  2, 0)); // PHT[2]=01
        vecs.push_back(mk(1, 0, 1, 32'h40,  1, 32'h100, 2, 0, 32'h40,  0, 32'h44,  2, 0)); // trains PHT[2], GHR=01
        vecs.push_back(mk(1, 0, 1, 32'h4C,  0, 32'h0,   0, 0, 32'h40,  0, 32'h44,  1, 0)); // PHT[3]->00, GHR=10
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h40,  1, 32'h100, 2, 0)); // PHT[2]=10
        vecs.push_back(mk(1, 1, 1, 32'h40,  1, 32'h100, 2, 1, 32'h40,  0, 32'h44,  2, 0)); // reset with update
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h40,  0, 32'h44,  0, 0));
        vecs.push_back(mk(1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h80,  0, 32'h84,  0, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // ---- dut0 counter wrap: count is 2, 14 more mispredicts reach 16 -> 0 ----
        for (int k = 0; k < 14; k++)
            apply(mk(0, 0, 1, 32'h1004, 0, 32'h0, 0, 1, 32'h1004, 0, 32'h1008, 0, 32'(2 + k)),
                  $sformatf("wrap%0d", k));
        apply(mk(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h1004, 0, 32'h1008, 0, 0), "wrap_zero");

        // ---- dut0 mid-run reset with a taken update: tables cleared ----
        apply(mk(0, 1, 1, 32'h80, 1, 32'h300, 0, 1, 32'h80, 0, 32'h84, 0, 0), "midrst");
        apply(mk(0, 0, 0, 32'h0,  0, 32'h0,   0, 0, 32'h80, 0, 32'h84, 0, 0), "midrst_80");
        apply(mk(0, 0, 0, 32'h0,  0, 32'h0,   0, 0, 32'h440, 0, 32'h444, 0, 0), "midrst_440");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the pipelined RV32 core. It combines a direct-mapped branch target buffer (BTB) with a pattern history table (PHT) of 2-bit saturating counters, indexed gshare-style by PC XOR global history. It sits beside the IF-stage PC adder and supplies the next fetch PC. EX-stage resolution feeds back through a one-cycle update port.

## Interface
- XLEN, 32, address/data width.
- ENTRIES, 16, number of BTB and PHT entries. Must be a power of 2, ≥ 2. IDX = log2(ENTRIES).
- HIST_BITS, 2, global history length. Range 0..IDX; 0 gives pure bimodal.
- CNT_W, 32, width of the misprediction counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- pc  in  XLEN  current fetch PC. Bits [1:0] are ignored.
- pred_taken  out  1  predict taken for pc.
- pred_target  out  XLEN  BTB target for pc. Valid only when pred_taken=1; otherwise drives pc+4.
- next_pc  out  XLEN  pred_taken ? pred_target : pc+4.
- pred_hist  out  max(HIST_BITS,1)  GHR snapshot used for this prediction, to be carried down the pipeline.
- update_valid  in  1  a branch or jump resolved this cycle.
- update_pc  in  XLEN  PC of the resolved instruction.
- update_taken  in  1  actual direction.
- update_target  in  XLEN  actual target.
- update_hist  in  max(HIST_BITS,1)  pred_hist captured when that instruction was fetched.
- update_mispredict  in  1  EX detected a wrong next_pc. Qualified by update_valid.
- mispredict_count  out  CNT_W  running count of mispredictions.

## Operation
- **Fields.** bidx = pc[IDX+1:2]; tag = pc[XLEN-1:IDX+2]; pidx = bidx XOR zero-extended GHR. With HIST_BITS=0, pidx = bidx.
- **Storage per BTB entry:** valid, tag, target.
- **Storage per PHT entry:** 2-bit counter. Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- **Lookup (combinational).** hit = valid[bidx] && tag match. pred_taken = hit && PHT[pidx][1]. pred_hist = GHR.
- **Update (on clk edge when update_valid=1).** Indices are recomputed from update_pc and update_hist, never from the live GHR.
  - PHT[update_pidx]: saturating increment if update_taken, saturating decrement otherwise. 11 stays 11; 00 stays 00.
  - BTB, taken: entry at update bidx gets valid=1, tag and target overwritten. This replaces any aliasing entry.
  - BTB, not taken: BTB is unchanged. A not-taken branch is never allocated.
  - GHR (HIST_BITS>0): GHR <= {GHR[HIST_BITS-2:0], update_taken}, i.e. a left shift with the newest bit at the LSB.
  - If update_mispredict: mispredict_count increments by 1 and wraps from 2^CNT_W-1 to 0.
- **Read-before-write.** When a lookup and an update hit the same entry in the same cycle, the lookup reflects the pre-update state. The new state is visible from the next cycle.
- **Reset.** All valid bits 0, all PHT counters 01, GHR 0, mispredict_count 0. While reset is high: pred_taken=0, next_pc=pc+4, and update_valid is ignored.
- **Reset mid-operation.** An update presented in the reset cycle is discarded. Table contents are lost.
- **Arithmetic.** pc+4 wraps modulo 2^XLEN: 0xFFFFFFFC gives 0x00000000.

## Timing
- Prediction is purely combinational from pc and registered state, with zero latency in the IF cycle.
- An update takes effect on the edge where update_valid=1. It is observable in the lookup of the following cycle (1-cycle update latency).
- There is one update per cycle. No handshake or backpressure; update_valid is a single-cycle strobe.
- All state elements are clocked only by the rising edge of clk.

## Test plan
- **Reset defaults.** ENTRIES=16, HIST_BITS=0; reset 2 cycles, pc=0x40 -> pred_taken=0, next_pc=0x44, mispredict_count=0.
- **Training and saturation.**
  - Update pc=0x40 taken, target=0x100 -> next cycle pred_taken=1, next_pc=0x100 (counter 01->10).
  - Two more taken updates, then one not-taken -> still taken (11->10).
  - One more not-taken -> pred_taken=0, next_pc=0x44.
- **Tag alias.** After the training above, pc=0x440 (same bidx 0, different tag) -> pred_taken=0, next_pc=0x444.
  - Taken update at 0x440, target=0x200 -> 0x440 predicts 0x200, and 0x40 now misses.
- **Same-cycle hazard.** pc=0x80 with a simultaneous first taken update at 0x80, target=0x300 -> that cycle next_pc=0x84; next cycle next_pc=0x300.
- **Global history.** HIST_BITS=2; updates taken then not-taken -> pred_hist=2'b10.
  - pc=0x40 indexes PHT[0 XOR 2]=PHT[2]. An update with update_hist=2'b10 trains PHT[2], not PHT[0].
- **Counter wrap and mid-run reset.** CNT_W=4; 16 mispredict updates -> mispredict_count=0.
  - Assert reset together with a taken update -> after reset, all lookups miss and GHR=0.
